// File: rtl/posit_locality.sv
// posit_locality: single-issue posit32 bit-pattern unit. Gathers up to three
// operands (immediate, memory via tagged reads, previous result, or zero),
// executes one operation, and holds the result record until it is accepted.
module posit_locality (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_request_valid,
    output logic        io_request_ready,
    input  logic [7:0]  io_request_bits_operands_0_value,
    input  logic [1:0]  io_request_bits_operands_0_mode,
    input  logic [7:0]  io_request_bits_operands_1_value,
    input  logic [1:0]  io_request_bits_operands_1_mode,
    input  logic [7:0]  io_request_bits_operands_2_value,
    input  logic [1:0]  io_request_bits_operands_2_mode,
    input  logic [2:0]  io_request_bits_inst,
    input  logic [1:0]  io_request_bits_mode,
    input  logic [7:0]  io_request_bits_wr_addr,
    output logic        io_mem_read_req_valid,
    output logic [7:0]  io_mem_read_req_addr,
    input  logic        io_mem_read_resp_valid,
    input  logic [7:0]  io_mem_read_resp_tag,
    input  logic [31:0] io_mem_read_data,
    output logic        io_mem_write_valid,
    input  logic        io_mem_write_ready,
    output logic [31:0] io_mem_write_bits_result_out,
    output logic        io_mem_write_bits_result_isZero,
    output logic        io_mem_write_bits_result_isNaR,
    output logic        io_mem_write_bits_result_lt,
    output logic        io_mem_write_bits_result_eq,
    output logic        io_mem_write_bits_result_gt,
    output logic [4:0]  io_mem_write_bits_result_exceptions,
    output logic [7:0]  io_mem_write_bits_wr_addr
);

    localparam logic [31:0] NAR = 32'h8000_0000;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EXEC, WRITE} state_t;

    state_t      state_reg, state_next;

    logic [7:0]  in_value [3];
    logic [1:0]  in_mode  [3];
    logic [31:0] acc_val  [3];
    logic [2:0]  acc_pend;
    logic [2:0]  acc_need;

    logic [31:0] op_val_reg  [3];
    logic [7:0]  op_addr_reg [3];
    logic [2:0]  pend_reg;
    logic [2:0]  need_reg;
    logic [2:0]  inst_reg;
    logic [1:0]  mode_reg;
    logic [7:0]  wr_addr_reg;
    logic [31:0] prev_result_reg;

    logic [31:0] res_out_reg;
    logic        res_zero_reg, res_nar_reg, res_lt_reg, res_eq_reg, res_gt_reg;
    logic [4:0]  res_exc_reg;
    logic [7:0]  res_wr_addr_reg;

    logic        accept;
    logic        collecting;
    logic [2:0]  cand;
    logic [2:0]  issue_oh;
    logic [7:0]  issue_addr;
    logic [2:0]  fill_hit;
    logic [2:0]  pend_after;
    logic [2:0]  need_after;

    assign in_value[0] = io_request_bits_operands_0_value;
    assign in_value[1] = io_request_bits_operands_1_value;
    assign in_value[2] = io_request_bits_operands_2_value;
    assign in_mode[0]  = io_request_bits_operands_0_mode;
    assign in_mode[1]  = io_request_bits_operands_1_mode;
    assign in_mode[2]  = io_request_bits_operands_2_mode;

    assign accept     = io_request_valid && (state_reg == IDLE);
    assign collecting = (state_reg == ISSUE) || (state_reg == WAIT);

    // Per-operand: value resolved at accept time, and whether a response fills it now.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_op
            assign acc_val[gi]  = (in_mode[gi] == 2'd0) ? {{24{in_value[gi][7]}}, in_value[gi]} :
                                  (in_mode[gi] == 2'd2) ? prev_result_reg : 32'd0;
            assign acc_pend[gi] = (in_mode[gi] == 2'd1);
            assign fill_hit[gi] = collecting && io_mem_read_resp_valid && pend_reg[gi] &&
                                  (op_addr_reg[gi] == io_mem_read_resp_tag);
        end
    endgenerate

    // Only the first operand naming a given address needs its own read.
    always_comb begin
        acc_need = acc_pend;
        for (int i = 1; i < 3; i++) begin
            for (int j = 0; j < i; j++) begin
                if (acc_pend[j] && (in_value[j] == in_value[i]))
                    acc_need[i] = 1'b0;
            end
        end
    end

    // Issue the lowest-numbered operand that still needs a read and is unfilled.
    always_comb begin
        cand       = (state_reg == ISSUE) ? (need_reg & pend_reg) : 3'b000;
        issue_oh   = cand & (~cand + 3'd1);
        issue_addr = 8'd0;
        for (int i = 0; i < 3; i++) begin
            if (issue_oh[i])
                issue_addr = op_addr_reg[i];
        end
        pend_after = pend_reg & ~fill_hit;
        need_after = need_reg & ~issue_oh & pend_after;
    end

    assign io_mem_read_req_valid = (cand != 3'b000);
    assign io_mem_read_req_addr  = issue_addr;
    assign io_request_ready      = (state_reg == IDLE);
    assign io_mem_write_valid    = (state_reg == WRITE);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (accept)
                       state_next = (acc_pend == 3'b000) ? EXEC : ISSUE;
            ISSUE: if (need_after == 3'b000)
                       state_next = (pend_after == 3'b000) ? EXEC : WAIT;
            WAIT:  if (pend_after == 3'b000)
                       state_next = EXEC;
            EXEC:  state_next = WRITE;
            WRITE: if (io_mem_write_ready)
                       state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Execute: opcode, then abs/negate modifiers; NaR passes through modifiers.
    logic [31:0] a, b, c, r_op, r_abs, r_fin;
    logic        nv, cmp_lt, cmp_eq, cmp_gt;
    always_comb begin
        a      = op_val_reg[0];
        b      = op_val_reg[1];
        c      = op_val_reg[2];
        cmp_lt = $signed(a) <  $signed(b);
        cmp_eq = (a == b);
        cmp_gt = $signed(a) >  $signed(b);
        r_op   = a;
        nv     = (a == NAR);
        case (inst_reg)
            3'd0: begin r_op = a;                 nv = (a == NAR) || (b == NAR); end
            3'd1: begin r_op = cmp_lt ? a : b;    nv = (a == NAR) || (b == NAR); end
            3'd2: begin r_op = cmp_gt ? a : b;    nv = (a == NAR) || (b == NAR); end
            3'd3: r_op = -a;
            3'd4: r_op = a[31] ? -a : a;
            3'd5: begin
                r_op = (c != 32'd0) ? a : b;
                nv   = (a == NAR) || (b == NAR) || (c == NAR);
            end
            3'd6: r_op = a;
            default: begin r_op = NAR;            nv = 1'b1; end
        endcase
        r_abs = (mode_reg[1] && (r_op != NAR) && r_op[31]) ? -r_op : r_op;
        r_fin = (mode_reg[0] && (r_abs != NAR)) ? -r_abs : r_abs;
    end

    // Datapath registers: request latch, operand fills, result capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                op_val_reg[i]  <= 32'd0;
                op_addr_reg[i] <= 8'd0;
            end
            pend_reg        <= 3'b000;
            need_reg        <= 3'b000;
            inst_reg        <= 3'd0;
            mode_reg        <= 2'd0;
            wr_addr_reg     <= 8'd0;
            prev_result_reg <= 32'd0;
            res_out_reg     <= 32'd0;
            res_zero_reg    <= 1'b0;
            res_nar_reg     <= 1'b0;
            res_lt_reg      <= 1'b0;
            res_eq_reg      <= 1'b0;
            res_gt_reg      <= 1'b0;
            res_exc_reg     <= 5'd0;
            res_wr_addr_reg <= 8'd0;
        end else begin
            if (accept) begin
                for (int i = 0; i < 3; i++) begin
                    op_val_reg[i]  <= acc_val[i];
                    op_addr_reg[i] <= in_value[i];
                end
                pend_reg    <= acc_pend;
                need_reg    <= acc_need;
                inst_reg    <= io_request_bits_inst;
                mode_reg    <= io_request_bits_mode;
                wr_addr_reg <= io_request_bits_wr_addr;
            end else if (collecting) begin
                for (int i = 0; i < 3; i++) begin
                    if (fill_hit[i])
                        op_val_reg[i] <= io_mem_read_data;
                end
                pend_reg <= pend_after;
                need_reg <= need_after;
            end
            if (state_reg == EXEC) begin
                res_out_reg     <= r_fin;
                res_zero_reg    <= (r_fin == 32'd0);
                res_nar_reg     <= (r_fin == NAR);
                res_lt_reg      <= cmp_lt;
                res_eq_reg      <= cmp_eq;
                res_gt_reg      <= cmp_gt;
                res_exc_reg     <= {nv, 4'b0000};
                res_wr_addr_reg <= wr_addr_reg;
                prev_result_reg <= r_fin;
            end
        end
    end

    assign io_mem_write_bits_result_out        = res_out_reg;
    assign io_mem_write_bits_result_isZero     = res_zero_reg;
    assign io_mem_write_bits_result_isNaR      = res_nar_reg;
    assign io_mem_write_bits_result_lt         = res_lt_reg;
    assign io_mem_write_bits_result_eq         = res_eq_reg;
    assign io_mem_write_bits_result_gt         = res_gt_reg;
    assign io_mem_write_bits_result_exceptions = res_exc_reg;
    assign io_mem_write_bits_wr_addr           = res_wr_addr_reg;

endmodule

// File: tb/tb_posit_locality.sv
// Directed bench for posit_locality: hand-computed vectors covering immediates,
// memory reads (single, shared, out-of-order), NaR, backpressure and reset.
module tb_posit_locality;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [7:0]  v0, v1, v2;
    logic [1:0]  m0, m1, m2;
    logic [2:0]  inst;
    logic [1:0]  rmode;
    logic [7:0]  wa;
    logic        rd_valid;
    logic [7:0]  rd_addr;
    logic        resp_valid;
    logic [7:0]  resp_tag;
    logic [31:0] resp_data;
    logic        wr_valid, wr_ready;
    logic [31:0] res_out;
    logic        is_zero, is_nar, lt, eq, gt;
    logic [4:0]  exc;
    logic [7:0]  wr_addr_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    posit_locality dut (
        .clock(clock), .reset(reset),
        .io_request_valid(req_valid), .io_request_ready(req_ready),
        .io_request_bits_operands_0_value(v0), .io_request_bits_operands_0_mode(m0),
        .io_request_bits_operands_1_value(v1), .io_request_bits_operands_1_mode(m1),
        .io_request_bits_operands_2_value(v2), .io_request_bits_operands_2_mode(m2),
        .io_request_bits_inst(inst), .io_request_bits_mode(rmode),
        .io_request_bits_wr_addr(wa),
        .io_mem_read_req_valid(rd_valid), .io_mem_read_req_addr(rd_addr),
        .io_mem_read_resp_valid(resp_valid), .io_mem_read_resp_tag(resp_tag),
        .io_mem_read_data(resp_data),
        .io_mem_write_valid(wr_valid), .io_mem_write_ready(wr_ready),
        .io_mem_write_bits_result_out(res_out),
        .io_mem_write_bits_result_isZero(is_zero), .io_mem_write_bits_result_isNaR(is_nar),
        .io_mem_write_bits_result_lt(lt), .io_mem_write_bits_result_eq(eq),
        .io_mem_write_bits_result_gt(gt),
        .io_mem_write_bits_result_exceptions(exc),
        .io_mem_write_bits_wr_addr(wr_addr_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request for a single cycle; returns at the negedge after acceptance.
    task automatic send(input logic [1:0] im0, input logic [7:0] iv0,
                        input logic [1:0] im1, input logic [7:0] iv1,
                        input logic [1:0] im2, input logic [7:0] iv2,
                        input logic [2:0] iinst, input logic [1:0] imode, input logic [7:0] iwa);
        @(negedge clock);
        chk("req_ready_before_send", {31'd0, req_ready}, 32'd1);
        m0 = im0; v0 = iv0; m1 = im1; v1 = iv1; m2 = im2; v2 = iv2;
        inst = iinst; rmode = imode; wa = iwa; req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    // Count further negedges until write_valid (bounded) and compare to expected.
    task automatic wait_write(input string tag, input int exp_n);
        int n = 0;
        while (!wr_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk(tag, n, exp_n);
    endtask

    task automatic check_result(input string tag, input logic [31:0] out,
                                input logic [4:0] flags, input logic [4:0] ex, input logic [7:0] a);
        $display("txn %s: out=0x%08h flags(z,n,lt,eq,gt)=%b exc=%b wr_addr=0x%02h",
                 tag, res_out, {is_zero, is_nar, lt, eq, gt}, exc, wr_addr_o);
        chk({tag, "_out"}, res_out, out);
        chk({tag, "_flags"}, {27'd0, is_zero, is_nar, lt, eq, gt}, {27'd0, flags});
        chk({tag, "_exc"}, {27'd0, exc}, {27'd0, ex});
        chk({tag, "_wr_addr"}, {24'd0, wr_addr_o}, {24'd0, a});
    endtask

    // Accept the pending result and confirm the unit is idle on the next cycle.
    task automatic finish_write(input string tag);
        wr_ready = 1'b1;
        @(negedge clock);
        chk({tag, "_idle_after_write"}, {30'd0, req_ready, wr_valid}, 32'b10);
        wr_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; wr_ready = 1'b0;
        v0 = 8'd0; v1 = 8'd0; v2 = 8'd0; m0 = 2'd0; m1 = 2'd0; m2 = 2'd0;
        inst = 3'd0; rmode = 2'd0; wa = 8'd0;
        resp_valid = 1'b0; resp_tag = 8'd0; resp_data = 32'd0;

        // Reset state
        repeat (2) @(negedge clock);
        chk("reset_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_valids", {30'd0, rd_valid, wr_valid}, 32'd0);
        chk("reset_rd_addr", {24'd0, rd_addr}, 32'd0);
        chk("reset_result", res_out, 32'd0);
        reset = 1'b0;

        // MAX(5, -2) with immediates: 5, gt
        send(2'd0, 8'h05, 2'd0, 8'hFE, 2'd3, 8'h00, 3'd2, 2'd0, 8'hA5);
        chk("max_no_read", {31'd0, rd_valid}, 32'd0);
        wait_write("max_latency", 1);
        check_result("max", 32'h0000_0005, 5'b00001, 5'b00000, 8'hA5);
        finish_write("max");

        // CMP with memory op0 at 0x10, imm op1 = 1
        send(2'd1, 8'h10, 2'd0, 8'h01, 2'd3, 8'h00, 3'd0, 2'd0, 8'h01);
        chk("mem_pulse", {23'd0, rd_valid, rd_addr}, {23'd0, 1'b1, 8'h10});
        @(negedge clock);
        chk("mem_single_pulse", {31'd0, rd_valid}, 32'd0);
        resp_valid = 1'b1; resp_tag = 8'h10; resp_data = 32'h4000_0000;
        @(negedge clock);
        resp_valid = 1'b0;
        chk("mem_no_extra_pulse", {31'd0, rd_valid}, 32'd0);
        wait_write("mem_latency", 1);
        check_result("mem", 32'h4000_0000, 5'b00001, 5'b00000, 8'h01);
        finish_write("mem");

        // MIN with both operands at shared address 0x22; response same cycle as issue
        send(2'd1, 8'h22, 2'd1, 8'h22, 2'd3, 8'h00, 3'd1, 2'd0, 8'h02);
        chk("shared_pulse", {23'd0, rd_valid, rd_addr}, {23'd0, 1'b1, 8'h22});
        resp_valid = 1'b1; resp_tag = 8'h22; resp_data = 32'h1234_5678;
        @(negedge clock);
        resp_valid = 1'b0;
        chk("shared_single_pulse", {31'd0, rd_valid}, 32'd0);
        wait_write("shared_latency", 1);
        check_result("shared", 32'h1234_5678, 5'b00010, 5'b00000, 8'h02);
        finish_write("shared");

        // ABS of NaR from memory: NaR preserved, NV set, NaR < 0
        send(2'd1, 8'h30, 2'd3, 8'h00, 2'd3, 8'h00, 3'd4, 2'd0, 8'h03);
        chk("nar_pulse", {23'd0, rd_valid, rd_addr}, {23'd0, 1'b1, 8'h30});
        @(negedge clock);
        resp_valid = 1'b1; resp_tag = 8'h30; resp_data = 32'h8000_0000;
        @(negedge clock);
        resp_valid = 1'b0;
        wait_write("nar_latency", 1);
        check_result("nar_abs", 32'h8000_0000, 5'b01100, 5'b10000, 8'h03);
        finish_write("nar_abs");

        // MOV of previous result (NaR), then hold write_ready low for 5 cycles
        send(2'd2, 8'h00, 2'd3, 8'h00, 2'd3, 8'h00, 3'd6, 2'd0, 8'h04);
        wait_write("prev_latency", 1);
        check_result("prev_mov", 32'h8000_0000, 5'b01100, 5'b10000, 8'h04);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("bp_hold", {29'd0, wr_valid, req_ready, is_nar}, 32'b101);
            chk("bp_out_stable", res_out, 32'h8000_0000);
        end
        finish_write("backpressure");

        // SEL out of order: op0@0x40, op1@0x41, op2 imm 1; abs modifier
        send(2'd1, 8'h40, 2'd1, 8'h41, 2'd0, 8'h01, 3'd5, 2'b10, 8'h05);
        chk("ooo_pulse0", {23'd0, rd_valid, rd_addr}, {23'd0, 1'b1, 8'h40});
        @(negedge clock);
        chk("ooo_pulse1", {23'd0, rd_valid, rd_addr}, {23'd0, 1'b1, 8'h41});
        resp_valid = 1'b1; resp_tag = 8'h55; resp_data = 32'hDEAD_BEEF;
        @(negedge clock);
        chk("ooo_no_pulse", {31'd0, rd_valid}, 32'd0);
        resp_tag = 8'h41; resp_data = 32'h0000_0007;
        @(negedge clock);
        resp_tag = 8'h40; resp_data = 32'hFFFF_FFF0;
        @(negedge clock);
        resp_valid = 1'b0;
        wait_write("ooo_latency", 1);
        check_result("ooo_sel", 32'h0000_0010, 5'b00100, 5'b00000, 8'h05);
        finish_write("ooo_sel");

        // Reset while waiting for memory, then a late response must be ignored
        send(2'd1, 8'h50, 2'd3, 8'h00, 2'd3, 8'h00, 3'd6, 2'd0, 8'h06);
        chk("rst_pulse", {23'd0, rd_valid, rd_addr}, {23'd0, 1'b1, 8'h50});
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rst_async_idle", {29'd0, req_ready, rd_valid, wr_valid}, 32'b100);
        chk("rst_clears_result", res_out, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        resp_valid = 1'b1; resp_tag = 8'h50; resp_data = 32'h1111_1111;
        @(negedge clock);
        resp_valid = 1'b0;
        begin
            logic seen = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (wr_valid) seen = 1'b1;
                @(negedge clock);
            end
            chk("rst_no_write", {31'd0, seen}, 32'd0);
        end
        send(2'd2, 8'h00, 2'd3, 8'h00, 2'd3, 8'h00, 3'd6, 2'd0, 8'h07);
        wait_write("after_rst_latency", 1);
        check_result("after_rst", 32'h0000_0000, 5'b10010, 5'b00000, 8'h07);
        finish_write("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/posit_locality.md
# posit_locality

Single-issue posit32 functional unit with operand locality: it accepts one instruction at a time, gathers up to three 32-bit operands, executes one bit-pattern posit operation, and emits one result record. Operands come from an immediate, host memory (tagged read port, one fetch per distinct address), or the previous result. The unit sits behind the AFU's MMIO decode and ahead of the CCI-P read/write request formatting.

## Interface
- Parameters: none.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- io_request_valid / io_request_ready  in / out  1 / 1  instruction handshake.
- io_request_bits_operands_{0,1,2}_value  in  8 each  immediate, memory address, or ignored.
- io_request_bits_operands_{0,1,2}_mode  in  2 each  operand source: 0 immediate, 1 memory, 2 previous result, 3 zero.
- io_request_bits_inst  in  3  opcode.
- io_request_bits_mode  in  2  result modifier: bit1 abs, bit0 negate.
- io_request_bits_wr_addr  in  8  result slot, passed through unchanged.
- io_mem_read_req_valid / io_mem_read_req_addr  out  1 / 8  one-cycle read pulse with address.
- io_mem_read_resp_valid / io_mem_read_resp_tag / io_mem_read_data  in  1 / 8 / 32  read response; tag equals the requested address.
- io_mem_write_valid / io_mem_write_ready  out / in  1 / 1  result handshake.
- io_mem_write_bits_result_out  out  32  result.
- io_mem_write_bits_result_isZero / _isNaR / _lt / _eq / _gt  out  1 each  status flags.
- io_mem_write_bits_result_exceptions  out  5  {NV,DZ,OF,UF,NX}.
- io_mem_write_bits_wr_addr  out  8  latched wr_addr.

## Operation
- FSM: IDLE, ISSUE, WAIT, EXEC, WRITE. Reset puts the FSM in IDLE and clears all registers, including prev_result (0).
- io_request_ready = (state==IDLE). A request is accepted on valid&&ready, and all request fields are latched.
- Operand resolution:
  - Mode 0: value sign-extended to 32 bits.
  - Mode 2: prev_result.
  - Mode 3: 0.
  - Mode 1: pending.
- If no operand is pending, the FSM goes to EXEC. Otherwise it goes to ISSUE.
- ISSUE: one read pulse per cycle, one per distinct pending address, in operand order 0,1,2. Operands sharing an address share one read. After the last issue, the FSM goes to WAIT, or directly to EXEC if all operands are already filled.
- Responses (ISSUE or WAIT): resp_valid with tag equal to a pending operand's address fills every pending operand with that address. Unmatched or duplicate responses are ignored. Out-of-order responses are legal.
- WAIT goes to EXEC when no operand is pending.
- EXEC computes r from operands a=op0, b=op1, c=op2. lt/eq/gt = signed compare of a vs b, for every opcode.
  - 0 CMP: r=a.
  - 1 MIN: signed minimum of a, b.
  - 2 MAX: signed maximum of a, b.
  - 3 NEG: r=-a (two's complement).
  - 4 ABS: r=a[31] ? -a : a.
  - 5 SEL: r = (c!=0) ? a : b.
  - 6 MOV: r=a.
  - 7 reserved: r=0x80000000, NV=1.
- Mode modifiers apply after the opcode: mode[1] applies abs, then mode[0] negates. NaR (0x80000000) is preserved by both.
- out=final r. isZero=(out==0). isNaR=(out==0x80000000).
- NV=1 if any operand used by the opcode is NaR, or for opcode 7. DZ, OF, UF and NX are always 0.
- EXEC latches all result fields and sets prev_result=out, then goes to WRITE.
- WRITE: valid=1 with all fields stable. On ready the FSM returns to IDLE.

## Timing
- Reset values: request_ready=1 (IDLE). mem_read_req_valid=0, mem_write_valid=0, all result bits 0, read address 0.
- No memory operands: accept at edge T, EXEC during T+1, write_valid high from T+2.
- Memory operands: the first read pulse occurs in the cycle after accept. EXEC occurs the cycle after the last fill.
- A response arriving in the same cycle as its address's issue pulse is captured.
- A request can be accepted the cycle after write_valid&&write_ready.
- Reset asserted mid-operation: returns to IDLE immediately, drops valid outputs, and clears prev_result. Responses arriving afterwards are ignored.

## Test plan
- MAX with immediates: op0 0x05, op1 0xFE (-> 0xFFFFFFFE), inst 2 -> out 0x00000005, gt=1, wr_addr echoed, write_valid 2 cycles after accept.
- Memory operand: op0 mode 1 addr 0x10, op1 imm 0x01, inst 0. Expect exactly one read pulse addr 0x10. Respond tag 0x10 data 0x40000000 -> out 0x40000000, gt=1.
- Shared address: op0/op1 both mode 1 addr 0x22, inst 1. Expect one read. Response 0x12345678 -> out 0x12345678, eq=1.
- NaR: op0 mem data 0x80000000, inst 4 -> out 0x80000000, isNaR=1, exceptions 5'b10000. Then op0 mode 2, inst 6 -> out 0x80000000.
- Backpressure: write_ready low for 5 cycles -> valid and fields stable, request_ready=0. Ready high -> IDLE next cycle.
- Reset during WAIT, then a late response -> no write_valid. The next request executes normally with prev_result=0.
